// File: rtl/fp_ret_collect.sv
// fp_ret_collect: retire-record collector for the low-half FP/SIMD cluster.
//
// Up to three retire records per cycle (lanes u1, u3, u5) enter an in-order
// FIFO. Enabled lanes are written compacted in lane order. The head entry goes
// to the retire logic over a valid/ready handshake. Each pop merges the
// record's IEEE flags into the sticky bits and raises a one-cycle trap when a
// flag is enabled in fpcsr[11:6].
//
// Ports:
//   clk, rst (async, active-low)
//   fpcsr[31:0]        trap enables in [11:6] for flags [5:0]
//   uN_ret[13:0]       {tag[7:0], flags[5:0]}, valid when uN_ret_en
//   flush              synchronous discard of all queued records
//   out_ready          retire logic accepts the head entry
//   out_valid/out_lane/out_ret  head entry (lane 0=u1, 1=u3, 2=u5)
//   stall              registered: fewer than 3 free entries
//   count              occupancy
//   fpsr_sticky        accumulated flags of popped records
//   trap/trap_tag      one-cycle trap pulse and tag of the trapping record
//   ovf_err            sticky: a record was dropped on a full FIFO
module fp_ret_collect #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     fpcsr,
  input  logic [13:0]     u1_ret,
  input  logic            u1_ret_en,
  input  logic [13:0]     u3_ret,
  input  logic            u3_ret_en,
  input  logic [13:0]     u5_ret,
  input  logic            u5_ret_en,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [1:0]      out_lane,
  output logic [13:0]     out_ret,
  output logic            stall,
  output logic [CNTW-1:0] count,
  output logic [5:0]      fpsr_sticky,
  output logic            trap,
  output logic [7:0]      trap_tag,
  output logic            ovf_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned XW = CNTW + 1;

  logic [13:0]     r_mem_ret  [DEPTH];
  logic [1:0]      r_mem_lane [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_stall;
  logic            r_ovf;
  logic            r_trap;
  logic [7:0]      r_trap_tag;
  logic [5:0]      r_sticky;

  logic [13:0]     w_ret [3];
  logic [2:0]      w_en;
  logic            w_pop;
  logic [XW-1:0]   w_room;
  logic [XW-1:0]   w_n_acc;
  logic [XW-1:0]   w_count_next;
  logic            w_stall_next;
  logic [2:0]      w_we;
  logic [PW-1:0]   w_idx [3];
  logic            w_drop;
  logic [13:0]     w_head_ret;
  logic [5:0]      w_trap_hits;
  logic            w_unused_fpcsr;

  assign w_ret[0] = u1_ret;
  assign w_ret[1] = u3_ret;
  assign w_ret[2] = u5_ret;
  assign w_en     = {u5_ret_en, u3_ret_en, u1_ret_en};

  assign w_unused_fpcsr = ^{fpcsr[31:12], fpcsr[5:0]};

  assign out_valid  = (r_count != '0);
  assign w_head_ret = r_mem_ret[r_rd_ptr];
  assign out_ret    = out_valid ? w_head_ret : '0;
  assign out_lane   = out_valid ? r_mem_lane[r_rd_ptr] : '0;

  assign w_trap_hits = w_head_ret[5:0] & fpcsr[11:6];

  // A pop frees its slot for this cycle's pushes; flush cancels both sides.
  // Lanes are accepted in u1, u3, u5 order while room remains, so an overflow
  // always drops the later lanes.
  always_comb begin
    w_pop   = out_valid && out_ready && !flush;
    w_room  = XW'(DEPTH) - {1'b0, r_count} + XW'(w_pop);
    w_n_acc = '0;
    w_drop  = 1'b0;
    w_we    = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_idx[i] = '0;
    end
    for (int unsigned i = 0; i < 3; i++) begin
      if (w_en[i] && !flush) begin
        if (w_n_acc < w_room) begin
          w_we[i]  = 1'b1;
          w_idx[i] = r_wr_ptr + PW'(w_n_acc);
          w_n_acc  = w_n_acc + XW'(1);
        end else begin
          w_drop = 1'b1;
        end
      end
    end
    if (flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = {1'b0, r_count} + w_n_acc - XW'(w_pop);
    end
    w_stall_next = (w_count_next > XW'(DEPTH - 3));
  end

  // Storage is not reset: entries are only observable while counted.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (w_we[i]) begin
        r_mem_ret[w_idx[i]]  <= w_ret[i];
        r_mem_lane[w_idx[i]] <= 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_ovf      <= 1'b0;
      r_trap     <= 1'b0;
      r_trap_tag <= '0;
      r_sticky   <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        r_wr_ptr <= r_wr_ptr + PW'(w_n_acc);
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
      r_count <= CNTW'(w_count_next);
      r_stall <= w_stall_next;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      r_trap <= w_pop && (w_trap_hits != '0);
      if (w_pop) begin
        r_sticky <= r_sticky | w_head_ret[5:0];
        if (w_trap_hits != '0) begin
          r_trap_tag <= w_head_ret[13:6];
        end
      end
    end
  end

  assign stall       = r_stall;
  assign count       = r_count;
  assign fpsr_sticky = r_sticky;
  assign trap        = r_trap;
  assign trap_tag    = r_trap_tag;
  assign ovf_err     = r_ovf;

endmodule
